// File: rtl/hist_eq_divider_pkg.sv
// Shared types and constants for the histogram-equalisation normalisation stage.
package hist_eq_divider_pkg;

    localparam int          LANE_W    = 32;
    localparam int          NUM_LANES = 4;
    localparam int          NUM_W     = LANE_W + 8;
    localparam int          NUM_WORDS = 64;
    localparam logic [15:0] CDF_BASE  = 16'h0000;
    localparam logic [15:0] OUT_BASE  = 16'h0040;
    localparam logic [7:0]  LEVELS    = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GETMAX,
        ST_LATMAX,
        ST_READ,
        ST_CAPT,
        ST_DIV,
        ST_WRITE
    } state_t;

    // Numerator (lane - cdf_min) * LEVELS; bins at or below cdf_min map to zero.
    function automatic logic [NUM_W-1:0] scale_lane(input logic [LANE_W-1:0] lane,
                                                    input logic [LANE_W-1:0] cmin);
        return (lane > cmin) ? NUM_W'(lane - cmin) * NUM_W'(LEVELS) : '0;
    endfunction

endpackage

// File: rtl/hist_eq_divider_if.sv
// Scratch-memory port bundle: two read ports, one write port, pass status strobes.
interface hist_eq_divider_if;
    import hist_eq_divider_pkg::*;

    logic [NUM_LANES*LANE_W-1:0] div_sc_mem_rd_data1;
    logic [NUM_LANES*LANE_W-1:0] div_sc_mem_rd_data2;
    logic [NUM_LANES*LANE_W-1:0] div_sc_mem_wt_data;
    logic [15:0]                 div_sc_mem_rd_addr1;
    logic [15:0]                 div_sc_mem_rd_addr2;
    logic [15:0]                 div_sc_mem_wt_addr;
    logic                        div_sc_mem_wt_en;
    logic                        div_sc_mem_rd_done;
    logic                        div_sc_mem_wt_done;

    modport master (
        input  div_sc_mem_rd_data1, div_sc_mem_rd_data2,
        output div_sc_mem_wt_data, div_sc_mem_rd_addr1, div_sc_mem_rd_addr2,
               div_sc_mem_wt_addr, div_sc_mem_wt_en, div_sc_mem_rd_done,
               div_sc_mem_wt_done
    );

    modport slave (
        output div_sc_mem_rd_data1, div_sc_mem_rd_data2,
        input  div_sc_mem_wt_data, div_sc_mem_rd_addr1, div_sc_mem_rd_addr2,
               div_sc_mem_wt_addr, div_sc_mem_wt_en, div_sc_mem_rd_done,
               div_sc_mem_wt_done
    );

endinterface

// File: rtl/hist_eq_divider_div_lane.sv
// 40/32-bit restoring divider, 8-bit saturating quotient over 8 cycles.
// The start cycle resolves quotient bit 7 so the result is final one cycle early.
module div_lane
    import hist_eq_divider_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [NUM_W-1:0]  dividend_i,
    input  logic [LANE_W-1:0] divisor_i,
    output logic              busy_o,
    output logic [7:0]        quot_o
);

    logic [NUM_W-1:0] rem_q, div_q;
    logic [NUM_W-1:0] rem_sel, div_sel, rem_d;
    logic [7:0]       quot_q;
    logic [2:0]       step_q;
    logic             busy_q, sat_q, zero_q, ge;

    always_comb begin
        rem_sel = start_i ? dividend_i : rem_q;
        div_sel = start_i ? {1'b0, divisor_i, 7'b0} : div_q;
        ge      = rem_sel >= div_sel;
        rem_d   = ge ? rem_sel - div_sel : rem_sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            div_q  <= '0;
            quot_q <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            sat_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= rem_d;
            div_q  <= div_sel >> 1;
            quot_q <= {7'b0, ge};
            step_q <= 3'd6;
            busy_q <= 1'b1;
            // Quotient of 256 or more cannot be represented: clamp to full scale.
            sat_q  <= dividend_i >= {divisor_i, 8'b0};
            zero_q <= divisor_i == '0;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            div_q  <= div_q >> 1;
            quot_q <= {quot_q[6:0], ge};
            if (step_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                step_q <= step_q - 3'd1;
            end
        end
    end

    assign busy_o = busy_q;
    assign quot_o = zero_q ? '0 : (sat_q ? LEVELS : quot_q);

endmodule

// File: rtl/hist_eq_divider.sv
// Maps each CDF bin to (cdf - cdf_min) * 255 / (cdf_max - cdf_min), one 128-bit word per 11 cycles.
//   state  | meaning
//   IDLE   | wait for enable
//   GETMAX | address last CDF word on port 2
//   LATMAX | latch cdf_min, range = cdf_max - cdf_min
//   READ   | address CDF word cnt on port 1
//   CAPT   | scale four lanes, start dividers
//   DIV    | 8 cycles of division
//   WRITE  | write mapped word, advance or finish
module hist_eq_divider
    import hist_eq_divider_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [LANE_W-1:0]  cdf_min,
    hist_eq_divider_if.master  mem
);

    state_t                      state_q;
    logic [5:0]                  cnt_q;
    logic [2:0]                  div_cnt_q;
    logic [LANE_W-1:0]           cdf_min_q, range_q;
    logic [15:0]                 rd_addr1_q, rd_addr2_q, wt_addr_q;
    logic [NUM_LANES*LANE_W-1:0] wt_data_q;
    logic                        wt_en_q, rd_done_q, wt_done_q;

    logic [NUM_W-1:0]            num_d [NUM_LANES];
    logic [7:0]                  quot  [NUM_LANES];
    logic [NUM_LANES-1:0]        busy;
    logic                        start_div, last_word;

    assign start_div = state_q == ST_CAPT;
    assign last_word = cnt_q == 6'(NUM_WORDS - 1);

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            num_d[k] = scale_lane(mem.div_sc_mem_rd_data1[k*LANE_W +: LANE_W], cdf_min_q);
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        div_lane u_div_lane (
            .clk       (clk),
            .reset     (reset),
            .start_i   (start_div),
            .dividend_i(num_d[k]),
            .divisor_i (range_q),
            .busy_o    (busy[k]),
            .quot_o    (quot[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_cnt_q  <= '0;
            cdf_min_q  <= '0;
            range_q    <= '0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
            wt_addr_q  <= '0;
            wt_data_q  <= '0;
            wt_en_q    <= 1'b0;
            rd_done_q  <= 1'b0;
            wt_done_q  <= 1'b0;
        end else begin
            wt_en_q   <= 1'b0;
            rd_done_q <= 1'b0;
            wt_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        cnt_q      <= '0;
                        rd_addr2_q <= CDF_BASE + 16'(NUM_WORDS - 1);
                        state_q    <= ST_GETMAX;
                    end
                end
                ST_GETMAX: state_q <= ST_LATMAX;
                ST_LATMAX: begin
                    cdf_min_q  <= cdf_min;
                    range_q    <= mem.div_sc_mem_rd_data2[4*LANE_W-1 -: LANE_W] - cdf_min;
                    rd_addr1_q <= CDF_BASE + {10'b0, cnt_q};
                    state_q    <= ST_READ;
                end
                ST_READ: state_q <= ST_CAPT;
                ST_CAPT: begin
                    rd_done_q <= last_word;
                    div_cnt_q <= 3'd7;
                    state_q   <= ST_DIV;
                end
                ST_DIV: begin
                    if (div_cnt_q != '0) begin
                        div_cnt_q <= div_cnt_q - 3'd1;
                    end else if (busy == '0) begin
                        wt_en_q   <= 1'b1;
                        wt_done_q <= last_word;
                        wt_addr_q <= OUT_BASE + {10'b0, cnt_q};
                        wt_data_q <= {24'b0, quot[3], 24'b0, quot[2],
                                      24'b0, quot[1], 24'b0, quot[0]};
                        state_q   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (last_word) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q      <= cnt_q + 6'd1;
                        rd_addr1_q <= CDF_BASE + {10'b0, cnt_q + 6'd1};
                        state_q    <= ST_READ;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem.div_sc_mem_rd_addr1 = rd_addr1_q;
    assign mem.div_sc_mem_rd_addr2 = rd_addr2_q;
    assign mem.div_sc_mem_wt_addr  = wt_addr_q;
    assign mem.div_sc_mem_wt_data  = wt_data_q;
    assign mem.div_sc_mem_wt_en    = wt_en_q;
    assign mem.div_sc_mem_rd_done  = rd_done_q;
    assign mem.div_sc_mem_wt_done  = wt_done_q;

endmodule

// File: tb/tb_hist_eq_divider.sv
// Bench for hist_eq_divider: scratch-memory model, write log and an arithmetic reference mapping.
module tb_hist_eq_divider;
    import hist_eq_divider_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] cdf_min;

    hist_eq_divider_if mif();

    hist_eq_divider dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .cdf_min(cdf_min),
        .mem    (mif)
    );

    always #5 clk = ~clk;

    logic [31:0]  cdf [256];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [15:0]  wr_addr_log [$];
    logic [127:0] wr_data_log [$];
    int           wr_cyc_log  [$];
    int           rd_done_total = 0;
    int           wt_done_total = 0;

    function automatic logic [127:0] mem_word(input logic [15:0] a);
        logic [127:0] w;
        int           i;
        w = '0;
        i = int'(a - CDF_BASE);
        if (i < NUM_WORDS) begin
            for (int k = 0; k < 4; k++) w[32*k +: 32] = cdf[4*i + k];
        end
        return w;
    endfunction

    // Reference mapping straight from the arithmetic rules, in 64-bit integers.
    function automatic logic [127:0] model_word(input int w, input logic [31:0] mn);
        logic [127:0]    r;
        logic [31:0]     d;
        longint unsigned q;
        r = '0;
        d = cdf[255] - mn;
        for (int k = 0; k < 4; k++) begin
            if (d == 0 || cdf[4*w + k] <= mn) begin
                q = 0;
            end else begin
                q = ((64'(cdf[4*w + k]) - 64'(mn)) * 64'd255) / 64'(d);
                if (q > 255) q = 255;
            end
            r[32*k +: 32] = 32'(q);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mif.div_sc_mem_rd_data1 <= mem_word(mif.div_sc_mem_rd_addr1);
        mif.div_sc_mem_rd_data2 <= mem_word(mif.div_sc_mem_rd_addr2);
    end

    always @(negedge clk) begin
        if (mif.div_sc_mem_wt_en) begin
            wr_addr_log.push_back(mif.div_sc_mem_wt_addr);
            wr_data_log.push_back(mif.div_sc_mem_wt_data);
            wr_cyc_log.push_back(cyc);
        end
        if (mif.div_sc_mem_rd_done) rd_done_total++;
        if (mif.div_sc_mem_wt_done) wt_done_total++;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_mono(output logic [31:0] mn);
        logic [31:0] acc;
        acc = $urandom_range(1, 40);
        for (int i = 0; i < 256; i++) begin
            cdf[i] = acc;
            acc += $urandom_range(0, 60);
        end
        mn = cdf[0];
    endtask

    // One pass; hold < 0 keeps enable high until the final write is seen.
    task automatic run_pass(input int hold, input logic [31:0] mn, output int base);
        int rdb, wdb, start, n;
        bit done;
        base = wr_addr_log.size();
        rdb  = rd_done_total;
        wdb  = wt_done_total;
        done = 1'b0;
        @(negedge clk);
        enable  = 1'b1;
        cdf_min = mn;
        start   = cyc;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k == hold) enable = 1'b0;
            if (mif.div_sc_mem_wt_done) begin
                enable = 1'b0;
                done   = 1'b1;
                break;
            end
        end
        enable = 1'b0;
        check_val("pass_done", 128'(done), 128'(1));
        repeat (20) @(negedge clk);
        n = wr_addr_log.size() - base;
        check_val("wr_count", 128'(n), 128'(NUM_WORDS));
        for (int w = 0; w < n && w < NUM_WORDS; w++) begin
            check_val($sformatf("wr_addr[%0d]", w), 128'(wr_addr_log[base+w]), 128'(OUT_BASE + 16'(w)));
            check_val($sformatf("wr_data[%0d]", w), wr_data_log[base+w], model_word(w, mn));
            if (w == 0)
                check_val("first_wr_latency", 128'(wr_cyc_log[base] - start), 128'(13));
            else
                check_val($sformatf("wr_spacing[%0d]", w),
                          128'(wr_cyc_log[base+w] - wr_cyc_log[base+w-1]), 128'(11));
        end
        check_val("rd_done_pulses", 128'(rd_done_total - rdb), 128'(1));
        check_val("wt_done_pulses", 128'(wt_done_total - wdb), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           base, seen, word, lane;
        logic [31:0]  mn, acc;
        logic [127:0] orr;

        reset   = 1'b1;
        enable  = 1'b0;
        cdf_min = '0;
        for (int i = 0; i < 256; i++) cdf[i] = '0;
        repeat (3) @(negedge clk);
        check_val("rst_wt_en",    128'(mif.div_sc_mem_wt_en),    128'(0));
        check_val("rst_wt_addr",  128'(mif.div_sc_mem_wt_addr),  128'(0));
        check_val("rst_wt_data",  mif.div_sc_mem_wt_data,        128'(0));
        check_val("rst_rd_addr1", 128'(mif.div_sc_mem_rd_addr1), 128'(0));
        check_val("rst_rd_addr2", 128'(mif.div_sc_mem_rd_addr2), 128'(0));
        check_val("rst_rd_done",  128'(mif.div_sc_mem_rd_done),  128'(0));
        check_val("rst_wt_done",  128'(mif.div_sc_mem_wt_done),  128'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Linear CDF: bin i maps exactly to level i.
        for (int i = 0; i < 256; i++) cdf[i] = 32'(18 * (i + 1));
        run_pass(10, 32'd18, base);
        if (wr_data_log.size() > base + 63) begin
            check_val("lin_word0", wr_data_log[base], {32'd3, 32'd2, 32'd1, 32'd0});
            check_val("lin_last_lane", 128'(wr_data_log[base+63][127:96]), 128'(255));
        end

        // Leading empty bins; cdf_min equals bin 10.
        for (int i = 0; i < 10; i++) cdf[i] = '0;
        acc = $urandom_range(5, 50);
        for (int i = 10; i < 256; i++) begin
            cdf[i] = acc;
            acc += $urandom_range(1, 50);
        end
        run_pass(10, cdf[10], base);
        for (int b = 0; b <= 10; b++) begin
            word = b / 4;
            lane = b % 4;
            if (wr_data_log.size() > base + word)
                check_val($sformatf("empty_bin[%0d]", b),
                          128'(wr_data_log[base+word][32*lane +: 32]), 128'(0));
        end

        // Flat CDF gives a zero range.
        for (int i = 0; i < 256; i++) cdf[i] = 32'd1000;
        run_pass(10, 32'd1000, base);
        orr = '0;
        for (int w = base; w < wr_data_log.size(); w++) orr |= wr_data_log[w];
        check_val("flat_all_zero", orr, 128'(0));

        // Enable held across the whole pass: exactly one pass.
        fill_mono(mn);
        run_pass(-1, mn, base);

        // Reset in the middle of write 20.
        fill_mono(mn);
        base = wr_addr_log.size();
        seen = 0;
        @(negedge clk);
        enable  = 1'b1;
        cdf_min = mn;
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (mif.div_sc_mem_wt_en) begin
                seen++;
                if (seen == 20) break;
            end
        end
        check_val("rst_reach_wr20", 128'(seen), 128'(20));
        #2 reset = 1'b1;
        #1;
        check_val("midrst_wt_en",   128'(mif.div_sc_mem_wt_en),   128'(0));
        check_val("midrst_wt_addr", 128'(mif.div_sc_mem_wt_addr), 128'(0));
        check_val("midrst_wt_data", mif.div_sc_mem_wt_data,       128'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check_val("midrst_no_more_wr", 128'(wr_addr_log.size() - base), 128'(20));
        run_pass(10, mn, base);

        // Unordered bins: some below cdf_min, some above cdf_max (saturate).
        for (int i = 0; i < 256; i++) cdf[i] = $urandom_range(0, 100000);
        cdf[255] = 32'd60000;
        run_pass(10, 32'd20000, base);

        // Unordered bins with zero range: everything maps to 0.
        for (int i = 0; i < 256; i++) cdf[i] = $urandom_range(0, 100000);
        cdf[255] = 32'd30000;
        run_pass(10, 32'd30000, base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
